rpn_tokenizer: RTL and testbench

Character-stream front end for the RPN calculator. It accepts ASCII characters over a valid/ready handshake, assembles decimal literals, and turns each literal or operator into one calculator command. Each command drives `push`/`op`/`d`, followed by a one-cycle `step` strobe. It sits directly upstream of the calculator, whose state advances on the rising edge of `step`.

---
 rtl/rpn_pkg.sv | 31 +++
 rtl/rpn_dec_acc.sv | 46 ++++
 rtl/rpn_tokenizer.sv | 179 +++++++++++++++++
 tb/tb_rpn_tokenizer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared constants and types for the RPN calculator and its tokenizer front end.
package rpn_pkg;

    // Calculator opcodes, valid when push = 0.
    localparam logic [1:0] OpNone = 2'd0;
    localparam logic [1:0] OpNeg  = 2'd1;
    localparam logic [1:0] OpAdd  = 2'd2;
    localparam logic [1:0] OpMul  = 2'd3;

    // ASCII codes recognised by the tokenizer.
    localparam logic [7:0] ChZero  = 8'h30;  // '0'
    localparam logic [7:0] ChNine  = 8'h39;  // '9'
    localparam logic [7:0] ChSpace = 8'h20;  // ' '
    localparam logic [7:0] ChPlus  = 8'h2B;  // '+'
    localparam logic [7:0] ChStar  = 8'h2A;  // '*'
    localparam logic [7:0] ChTilde = 8'h7E;  // '~'
    localparam logic [7:0] ChEqual = 8'h3D;  // '='

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StDone
    } state_e;

    // True for '0'..'9'.
    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ChZero) && (c <= ChNine);
    endfunction

endpackage

// File: rtl/rpn_dec_acc.sv
// Decimal literal accumulator: acc = acc*10 + digit (mod 2^N), with a pending flag.
module rpn_dec_acc
    import rpn_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         digit_en_i,
    input  logic [3:0]   digit_i,
    input  logic         clear_i,
    output logic [N-1:0] acc_o,
    output logic         pend_o
);

    logic [N-1:0] acc_q, acc_d;
    logic         pend_q, pend_d;

    // Next accumulator value; clear on issue takes priority over a digit.
    always_comb begin
        acc_d  = acc_q;
        pend_d = pend_q;
        if (clear_i) begin
            acc_d  = '0;
            pend_d = 1'b0;
        end else if (digit_en_i) begin
            acc_d  = N'(acc_q * N'(10)) + N'(digit_i);
            pend_d = 1'b1;
        end
    end

    // Accumulator state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            pend_q <= pend_d;
        end
    end

    assign acc_o  = acc_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/rpn_tokenizer.sv
// Character-stream tokenizer: turns ASCII literals/operators into strobed calculator commands.
module rpn_tokenizer
    import rpn_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [7:0]   ch_i,
    output logic         step_o,
    output logic         push_o,
    output logic [1:0]   op_o,
    output logic [N-1:0] d_o,
    output logic         done_o,
    output logic         err_o
);

    state_e       state_q, state_d;
    logic         push_q, push_d;
    logic [1:0]   op_q, op_d;
    logic [N-1:0] d_q, d_d;
    logic         step_q, step_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    // Second command queued behind a push: an op, or the done pulse.
    logic         qop_vld_q, qop_vld_d;
    logic [1:0]   qop_q, qop_d;
    logic         qdone_q, qdone_d;

    logic         accept;
    logic         ch_digit;
    logic [3:0]   digit;
    logic         ch_op;
    logic [1:0]   ch_opc;
    logic         digit_en;
    logic         acc_clear;
    logic [N-1:0] acc;
    logic         pend;

    assign in_ready_o = (state_q == StIdle);
    assign accept     = in_valid_i && in_ready_o;

    // Character classification.
    always_comb begin
        ch_digit = is_digit(ch_i);
        digit    = 4'(ch_i - ChZero);
        ch_op    = 1'b1;
        ch_opc   = OpNone;
        unique case (ch_i)
            ChPlus:  ch_opc = OpAdd;
            ChStar:  ch_opc = OpMul;
            ChTilde: ch_opc = OpNeg;
            default: ch_op  = 1'b0;
        endcase
    end

    rpn_dec_acc #(
        .N (N)
    ) u_dec_acc (
        .clk        (clk),
        .nrst       (nrst),
        .digit_en_i (digit_en),
        .digit_i    (digit),
        .clear_i    (acc_clear),
        .acc_o      (acc),
        .pend_o     (pend)
    );

    // FSM next state, command loading and accumulator control.
    always_comb begin
        state_d   = state_q;
        push_d    = push_q;
        op_d      = op_q;
        d_d       = d_q;
        err_d     = err_q;
        qop_vld_d = qop_vld_q;
        qop_d     = qop_q;
        qdone_d   = qdone_q;
        digit_en  = 1'b0;
        acc_clear = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (ch_digit) begin
                        digit_en = 1'b1;
                    end else if (ch_i == ChSpace || ch_op || ch_i == ChEqual) begin
                        if (pend) begin
                            push_d    = 1'b1;
                            op_d      = OpNone;
                            d_d       = acc;
                            acc_clear = 1'b1;
                            state_d   = StSetup;
                            if (ch_op) begin
                                qop_vld_d = 1'b1;
                                qop_d     = ch_opc;
                            end
                            if (ch_i == ChEqual) begin
                                qdone_d = 1'b1;
                            end
                        end else if (ch_op) begin
                            push_d  = 1'b0;
                            op_d    = ch_opc;
                            state_d = StSetup;
                        end else if (ch_i == ChEqual) begin
                            state_d = StDone;
                        end
                    end else begin
                        // Illegal character is dropped; only the sticky flag records it.
                        err_d = 1'b1;
                    end
                end
            end
            StSetup: begin
                state_d = StStrobe;
            end
            StStrobe: begin
                if (qop_vld_q) begin
                    push_d    = 1'b0;
                    op_d      = qop_q;
                    qop_vld_d = 1'b0;
                    state_d   = StSetup;
                end else if (qdone_q) begin
                    qdone_d = 1'b0;
                    state_d = StDone;
                end else begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Strobes come straight from flops so the calculator sees clean edges.
        step_d = (state_d == StStrobe);
        done_d = (state_d == StDone);
    end

    // State, command and strobe registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= StIdle;
            push_q    <= 1'b0;
            op_q      <= OpNone;
            d_q       <= '0;
            step_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            qop_vld_q <= 1'b0;
            qop_q     <= OpNone;
            qdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            push_q    <= push_d;
            op_q      <= op_d;
            d_q       <= d_d;
            step_q    <= step_d;
            done_q    <= done_d;
            err_q     <= err_d;
            qop_vld_q <= qop_vld_d;
            qop_q     <= qop_d;
            qdone_q   <= qdone_d;
        end
    end

    assign step_o = step_q;
    assign push_o = push_q;
    assign op_o   = op_q;
    assign d_o    = d_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_rpn_tokenizer.sv
// Directed bench for rpn_tokenizer: vector table plus hand-written timing/reset sequences.
module tb_rpn_tokenizer;
    import rpn_pkg::*;

    localparam int unsigned N = 16;

    typedef logic [18:0] cmd_t;  // {push, op, d}

    typedef struct {
        string             s;
        int                ncmd;
        logic [3:0][18:0]  c;
        int                ndone;
        logic              err;
    } vec_t;

    logic         clk = 1'b0;
    logic         nrst;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [7:0]   ch_i;
    logic         step_o;
    logic         push_o;
    logic [1:0]   op_o;
    logic [N-1:0] d_o;
    logic         done_o;
    logic         err_o;

    int total = 0;
    int bad   = 0;

    cmd_t got_q[$];
    int   rise_cyc[$];
    int   done_cnt = 0;
    int   cyc = 0;
    logic step_prev = 1'b0;
    cmd_t prev_cmd = '0;

    vec_t vecs[8];

    rpn_tokenizer #(
        .N (N)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .ch_i       (ch_i),
        .step_o     (step_o),
        .push_o     (push_o),
        .op_o       (op_o),
        .d_o        (d_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    // Record every command at its step rise and check it was stable the cycle before.
    always @(negedge clk) begin
        cyc++;
        if (step_o && !step_prev) begin
            got_q.push_back({push_o, op_o, d_o});
            rise_cyc.push_back(cyc);
            total++;
            if ({push_o, op_o, d_o} !== prev_cmd) begin
                bad++;
                $display("FAIL cmd_stable got=%h want=%h", {push_o, op_o, d_o}, prev_cmd);
            end
            total++;
            if (!push_o && op_o == OpNone) begin
                bad++;
                $display("FAIL op_none_at_strobe got=%0d want=nonzero", op_o);
            end
        end
        if (done_o) done_cnt++;
        step_prev = step_o;
        prev_cmd  = {push_o, op_o, d_o};
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic clear_log();
        got_q.delete();
        rise_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset(input string tag);
        in_valid_i = 1'b0;
        ch_i       = 8'h00;
        nrst       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_rst_step"},  32'(step_o),     32'd0);
        check({tag, "_rst_push"},  32'(push_o),     32'd0);
        check({tag, "_rst_op"},    32'(op_o),       32'd0);
        check({tag, "_rst_d"},     32'(d_o),        32'd0);
        check({tag, "_rst_done"},  32'(done_o),     32'd0);
        check({tag, "_rst_err"},   32'(err_o),      32'd0);
        check({tag, "_rst_ready"}, 32'(in_ready_o), 32'd1);
        nrst = 1'b1;
        @(negedge clk);
        clear_log();
    endtask

    // Present each character with in_valid held high until it is taken.
    task automatic send_str(input string s);
        for (int k = 0; k < s.len(); k++) begin
            int w;
            ch_i       = s[k];
            in_valid_i = 1'b1;
            w          = 0;
            while (!in_ready_o && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w >= 20) begin
                total++;
                bad++;
                $display("FAIL ready_timeout got=0 want=1");
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid_i = 1'b0;
    endtask

    initial begin
        int n;
        in_valid_i = 1'b0;
        ch_i       = 8'h00;
        nrst       = 1'b0;

        vecs[0].s = "12 3+=";  vecs[0].ncmd = 3; vecs[0].ndone = 1; vecs[0].err = 1'b0;
        vecs[0].c[0] = {1'b1, OpNone, 16'd12};
        vecs[0].c[1] = {1'b1, OpNone, 16'd3};
        vecs[0].c[2] = {1'b0, OpAdd, 16'd0};
        vecs[0].c[3] = '0;
        vecs[1].s = "7~=";     vecs[1].ncmd = 2; vecs[1].ndone = 1; vecs[1].err = 1'b0;
        vecs[1].c[0] = {1'b1, OpNone, 16'd7};
        vecs[1].c[1] = {1'b0, OpNeg, 16'd0};
        vecs[1].c[2] = '0; vecs[1].c[3] = '0;
        vecs[2].s = "65537 ";  vecs[2].ncmd = 1; vecs[2].ndone = 0; vecs[2].err = 1'b0;
        vecs[2].c[0] = {1'b1, OpNone, 16'd1};
        vecs[2].c[1] = '0; vecs[2].c[2] = '0; vecs[2].c[3] = '0;
        vecs[3].s = "4x5*";    vecs[3].ncmd = 2; vecs[3].ndone = 0; vecs[3].err = 1'b1;
        vecs[3].c[0] = {1'b1, OpNone, 16'd45};
        vecs[3].c[1] = {1'b0, OpMul, 16'd0};
        vecs[3].c[2] = '0; vecs[3].c[3] = '0;
        vecs[4].s = "9*7 ";    vecs[4].ncmd = 3; vecs[4].ndone = 0; vecs[4].err = 1'b0;
        vecs[4].c[0] = {1'b1, OpNone, 16'd9};
        vecs[4].c[1] = {1'b0, OpMul, 16'd0};
        vecs[4].c[2] = {1'b1, OpNone, 16'd7};
        vecs[4].c[3] = '0;
        vecs[5].s = "+ ~";     vecs[5].ncmd = 2; vecs[5].ndone = 0; vecs[5].err = 1'b0;
        vecs[5].c[0] = {1'b0, OpAdd, 16'd0};
        vecs[5].c[1] = {1'b0, OpNeg, 16'd0};
        vecs[5].c[2] = '0; vecs[5].c[3] = '0;
        vecs[6].s = "=";       vecs[6].ncmd = 0; vecs[6].ndone = 1; vecs[6].err = 1'b0;
        vecs[6].c = '0;
        vecs[7].s = "007 250="; vecs[7].ncmd = 2; vecs[7].ndone = 1; vecs[7].err = 1'b0;
        vecs[7].c[0] = {1'b1, OpNone, 16'd7};
        vecs[7].c[1] = {1'b1, OpNone, 16'd250};
        vecs[7].c[2] = '0; vecs[7].c[3] = '0;

        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            do_reset(tag);
            send_str(vecs[i].s);
            repeat (8) @(negedge clk);
            check({tag, "_ncmd"}, 32'(got_q.size()), 32'(vecs[i].ncmd));
            for (int j = 0; j < vecs[i].ncmd && j < got_q.size(); j++) begin
                if (vecs[i].c[j][18]) begin
                    check($sformatf("%s_cmd%0d", tag, j), 32'(got_q[j]), 32'(vecs[i].c[j]));
                end else begin
                    check($sformatf("%s_op%0d", tag, j), 32'(got_q[j][18:16]),
                          32'(vecs[i].c[j][18:16]));
                end
            end
            check({tag, "_done"}, 32'(done_cnt), 32'(vecs[i].ndone));
            check({tag, "_err"},  32'(err_o),    32'(vecs[i].err));
        end

        // "7~=": busy windows and strobe spacing.
        do_reset("busy");
        ch_i = "7"; in_valid_i = 1'b1;
        @(posedge clk); @(negedge clk);
        ch_i = "~";
        @(posedge clk); @(negedge clk);
        in_valid_i = 1'b0;
        n = 0;
        while (!in_ready_o && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("busy_push_op", 32'(n), 32'd4);
        ch_i = "="; in_valid_i = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid_i = 1'b0;
        n = 0;
        while (!in_ready_o && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("busy_eq_nopend", 32'(n), 32'd1);
        repeat (3) @(negedge clk);
        check("busy_nstrobe", 32'(rise_cyc.size()), 32'd2);
        if (rise_cyc.size() >= 2) begin
            check("strobe_gap", 32'(rise_cyc[1] - rise_cyc[0]), 32'd2);
        end
        check("busy_done", 32'(done_cnt), 32'd1);

        // Reset while strobing "8 ": everything drops at once, then "2=" runs clean.
        do_reset("mid");
        send_str("8");
        ch_i = " "; in_valid_i = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid_i = 1'b0;
        @(posedge clk); @(negedge clk);
        check("mid_pre_step", 32'(step_o), 32'd1);
        check("mid_pre_d",    32'(d_o),    32'd8);
        #1 nrst = 1'b0;
        #1;
        check("mid_step",  32'(step_o),     32'd0);
        check("mid_push",  32'(push_o),     32'd0);
        check("mid_d",     32'(d_o),        32'd0);
        check("mid_ready", 32'(in_ready_o), 32'd1);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        clear_log();
        send_str("2=");
        repeat (8) @(negedge clk);
        check("mid_ncmd", 32'(got_q.size()), 32'd1);
        if (got_q.size() >= 1) begin
            check("mid_cmd0", 32'(got_q[0]), 32'({1'b1, OpNone, 16'd2}));
        end
        check("mid_done", 32'(done_cnt), 32'd1);
        check("mid_err",  32'(err_o),    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
